// File: rtl/misr_pkg.sv
// misr_pkg: shared state type and default feedback/seed constants for the MISR
package misr_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} misr_state_e;
  localparam logic [7:0] DEF_POLY = 8'h1D;
  localparam logic [7:0] DEF_SEED = 8'h00;
endpackage

// File: rtl/misr_step.sv
// misr_step: combinational Galois-form signature step (shift, conditional tap XOR, data XOR)
module misr_step #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(8'h1D)
) (
  input  logic [WIDTH-1:0] sig_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] next_o
);
  assign next_o = {sig_i[WIDTH-2:0], 1'b0} ^ (sig_i[WIDTH-1] ? POLY : '0) ^ din_i;
endmodule

// File: rtl/misr_signature_reg.sv
// misr_signature_reg: run/done MISR compressing LEN capture words; optional signature check under SIG_COMPARE_EN
module misr_signature_reg
  import misr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(DEF_SEED),
  parameter int LEN = 16,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic             sys_clk,
  input  logic             sys_rstb,
  input  logic             start,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
`ifdef SIG_COMPARE_EN
  input  logic [WIDTH-1:0] exp_sig,
  output logic             pass,
  output logic             fail,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sig,
  output logic [CNT_W-1:0] cnt
);
  misr_state_e state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d, step_nx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic cap, last, reseed;
  misr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_step (
    .sig_i (sig_q),
    .din_i (din),
    .next_o(step_nx)
  );
  assign reseed = clear | start;
  assign cap    = (state_q == RUN) & din_valid;
  assign last   = cap & (cnt_q == CNT_W'(LEN - 1));
  // state register
  always_ff @(posedge sys_clk or negedge sys_rstb)
    if (!sys_rstb) state_q <= IDLE;
    else state_q <= state_d;
  // next state: clear beats start beats the final capture
  always_comb
    state_d = clear ? IDLE : start ? RUN : last ? DONE : (state_q == IDLE || state_q == RUN || state_q == DONE) ? state_q : IDLE;
  // status outputs decode the registered state
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end
  // signature and capture-count next values
  always_comb begin
    sig_d = reseed ? SEED : cap ? step_nx : sig_q;
    cnt_d = reseed ? '0 : cap ? cnt_q + CNT_W'(1) : cnt_q;
  end
  // signature and capture-count registers
  always_ff @(posedge sys_clk or negedge sys_rstb)
    if (!sys_rstb) begin
      sig_q <= SEED;
      cnt_q <= '0;
    end else begin
      sig_q <= sig_d;
      cnt_q <= cnt_d;
    end
  assign sig = sig_q;
  assign cnt = cnt_q;
`ifdef SIG_COMPARE_EN
  logic pass_q, pass_d, fail_q, fail_d;
  // verdict is taken from the final step value on the DONE-entry edge
  always_comb begin
    pass_d = reseed ? 1'b0 : last ? (step_nx == exp_sig) : pass_q;
    fail_d = reseed ? 1'b0 : last ? (step_nx != exp_sig) : fail_q;
  end
  // verdict registers
  always_ff @(posedge sys_clk or negedge sys_rstb)
    if (!sys_rstb) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  assign pass = pass_q;
  assign fail = fail_q;
`endif
endmodule
